// File: rtl/icache_refill_pkg.sv
// -----------------------------------------------------------------------------
// icache_refill_pkg
// Shared definitions for the I-cache line refill engine: default line
// geometry, FSM state encoding and the line-aligned address mask.
// -----------------------------------------------------------------------------
package icache_refill_pkg;

    localparam int LINE_WORDS_DEF = 8;
    localparam int OFF_W_DEF      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_READY = 2'd2,
        ST_ABORT = 2'd3
    } state_e;

    // Mask that clears the word-offset and byte-offset bits of an address.
    function automatic logic [31:0] line_mask(input int off_w);
        return ~((32'd1 << (off_w + 2)) - 32'd1);
    endfunction

    localparam logic [31:0] LINE_ADDR_MASK = line_mask(OFF_W_DEF);

endpackage

// File: rtl/icache_refill_if.sv
// -----------------------------------------------------------------------------
// icache_refill_if
// Bundles the controller-side fill handshake and the memory-bus read port.
//   mem_r/miss_addr        : fill request from the I-cache controller
//   mem_ready/line_data    : completed line back to the controller
//   fill_err               : bus error pulse
//   bus_req/bus_addr       : word read request to memory
//   bus_ack/bus_rdata/bus_err : beat response from memory
// modport slave  : the refill engine
// modport master : the surroundings (controller + memory model)
// -----------------------------------------------------------------------------
interface icache_refill_if
    import icache_refill_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF
);
    logic                      mem_r;
    logic [31:0]               miss_addr;
    logic                      mem_ready;
    logic [32*LINE_WORDS-1:0]  line_data;
    logic                      fill_err;
    logic                      bus_req;
    logic [31:0]               bus_addr;
    logic                      bus_ack;
    logic [31:0]               bus_rdata;
    logic                      bus_err;

    modport slave (
        input  mem_r, miss_addr, bus_ack, bus_rdata, bus_err,
        output mem_ready, line_data, fill_err, bus_req, bus_addr
    );

    modport master (
        output mem_r, miss_addr, bus_ack, bus_rdata, bus_err,
        input  mem_ready, line_data, fill_err, bus_req, bus_addr
    );
endinterface

// File: rtl/icache_line_buf.sv
// -----------------------------------------------------------------------------
// icache_line_buf
// Assembly buffer for one cache line: LINE_WORDS x 32-bit registers with a
// per-word write enable and a synchronous clear of the whole line.
//   clk      : clock
//   clr_i    : clear all words (wins over writes)
//   we_i     : one-hot word write enable
//   wdata_i  : write data
//   words_o  : all words, word i at bits [32i+31:32i]
// -----------------------------------------------------------------------------
module icache_line_buf
    import icache_refill_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic                     clk,
    input  logic                     clr_i,
    input  logic [LINE_WORDS-1:0]    we_i,
    input  logic [31:0]              wdata_i,
    output logic [32*LINE_WORDS-1:0] words_o
);

    logic [32*LINE_WORDS-1:0] words_q;

    // NOTE: this storage is cleared on reset (through clr_i) because the
    // visible line must read as zero after reset; plain data RAMs normally
    // stay unreset.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            words_q <= '0;
        end else begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                if (we_i[i]) begin
                    words_q[32*i +: 32] <= wdata_i;
                end
            end
        end
    end

    assign words_o = words_q;

endmodule

// File: rtl/icache_refill.sv
// -----------------------------------------------------------------------------
// icache_refill
// Fetches one cache line, critical word first, wrapping within the line.
// Beats are assembled in icache_line_buf; the visible line_data register is
// loaded only when the last beat lands, so an aborted or failed fill never
// disturbs the line previously delivered.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   ifc  : icache_refill_if.slave (controller handshake + memory bus)
// -----------------------------------------------------------------------------
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int OFF_W      = OFF_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    icache_refill_if.slave ifc
);

    localparam logic [31:0]      ADDR_MASK = line_mask(OFF_W);
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    state_e                    state_q, state_d;
    logic [31:0]               base_q, base_d;
    logic [OFF_W-1:0]          start_q, start_d;
    logic [OFF_W-1:0]          count_q, count_d;
    logic                      fill_err_q, fill_err_d;
    logic [32*LINE_WORDS-1:0]  line_q, line_d;

    logic [OFF_W-1:0]          beat_idx;
    logic [LINE_WORDS-1:0]     buf_we;
    logic                      buf_clr;
    logic                      commit;
    logic [32*LINE_WORDS-1:0]  buf_words;

    // OFF_W-wide addition wraps modulo LINE_WORDS for free.
    assign beat_idx = start_q + count_q;

    icache_line_buf #(
        .LINE_WORDS (LINE_WORDS)
    ) u_line_buf (
        .clk     (clk),
        .clr_i   (rst | buf_clr),
        .we_i    (buf_we),
        .wdata_i (ifc.bus_rdata),
        .words_o (buf_words)
    );

    // NOTE: every signal assigned in this block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        start_d    = start_q;
        count_d    = count_q;
        fill_err_d = 1'b0;
        buf_we     = '0;
        buf_clr    = 1'b0;
        commit     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ifc.mem_r) begin
                    base_d  = ifc.miss_addr & ADDR_MASK;
                    start_d = ifc.miss_addr[OFF_W+1:2];
                    count_d = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (!ifc.mem_r) begin
                    // Controller withdrew: a beat acked this cycle closes the
                    // abort immediately, otherwise wait for it in ABORT.
                    if (ifc.bus_ack) begin
                        buf_clr = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_ABORT;
                    end
                end else if (ifc.bus_ack) begin
                    if (ifc.bus_err) begin
                        fill_err_d = 1'b1;
                        buf_clr    = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        buf_we[beat_idx] = 1'b1;
                        count_d          = count_q + OFF_W'(1);
                        if (count_q == LAST_BEAT) begin
                            commit  = 1'b1;
                            state_d = ST_READY;
                        end
                    end
                end
            end
            ST_READY: begin
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                // count is frozen, so bus_addr stays on the pending beat.
                if (ifc.bus_ack) begin
                    buf_clr = 1'b1;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // The last beat is merged straight from the bus because it is being
    // written into the buffer on the same edge.
    always_comb begin
        line_d = line_q;
        if (commit) begin
            line_d                      = buf_words;
            line_d[32*beat_idx +: 32]   = ifc.bus_rdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            start_q    <= '0;
            count_q    <= '0;
            fill_err_q <= 1'b0;
            line_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            start_q    <= start_d;
            count_q    <= count_d;
            fill_err_q <= fill_err_d;
            line_q     <= line_d;
        end
    end

    assign ifc.mem_ready = (state_q == ST_READY);
    assign ifc.bus_req   = (state_q == ST_BUS) || (state_q == ST_ABORT);
    assign ifc.bus_addr  = base_q | (32'(beat_idx) << 2);
    assign ifc.fill_err  = fill_err_q;
    assign ifc.line_data = line_q;

endmodule

// File: tb/tb_icache_refill.sv
// -----------------------------------------------------------------------------
// tb_icache_refill
// Directed bench for icache_refill. Inputs change and outputs are checked on
// the falling clock edge. Read data for a beat is address + per-fill salt,
// so every expected line word is base + 4*i + salt.
// -----------------------------------------------------------------------------
module tb_icache_refill;

    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    icache_refill_if #(.LINE_WORDS(LW)) bus_if ();

    icache_refill #(
        .LINE_WORDS (LW),
        .OFF_W      (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ifc (bus_if)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    int          ready_seen = 0;
    int          err_seen   = 0;
    logic [31:0] salt;

    // Pulse counters sampled mid-cycle, away from both edges used elsewhere.
    always @(posedge clk) begin
        #2;
        if (bus_if.mem_ready === 1'b1) ready_seen++;
        if (bus_if.fill_err === 1'b1) err_seen++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_line(input string tag, input logic [31:0] base, input logic [31:0] s);
        for (int i = 0; i < LW; i++)
            check($sformatf("%s_w%0d", tag, i), bus_if.line_data[32*i +: 32], base + 32'(4*i) + s);
    endtask

    // One beat: hold for 'waits' cycles checking address stability, then ack.
    task automatic do_beat(input logic [31:0] addr, input int waits, input logic err);
        for (int w = 0; w < waits; w++) begin
            check("wait_addr_hold", bus_if.bus_addr, addr);
            check("wait_bus_req", bus_if.bus_req, 1);
            tick();
        end
        check("bus_req", bus_if.bus_req, 1);
        check("bus_addr", bus_if.bus_addr, addr);
        check("no_early_ready", bus_if.mem_ready, 0);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_err   = err;
        bus_if.bus_rdata = addr + salt;
        tick();
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_err   = 1'b0;
        bus_if.bus_rdata = 32'hDEAD_BEEF;
    endtask

    // Complete fill: request, LW beats, check the READY cycle and the line.
    task automatic full_fill(input logic [31:0] maddr, input int waits, input logic [31:0] s);
        logic [31:0] base;
        int          start;
        salt  = s;
        base  = maddr & 32'hFFFF_FFE0;
        start = int'(maddr[4:2]);
        bus_if.mem_r     = 1'b1;
        bus_if.miss_addr = maddr;
        tick();
        for (int k = 0; k < LW; k++)
            do_beat(base + 32'(((start + k) % LW) * 4), waits, 1'b0);
        check("mem_ready_pulse", bus_if.mem_ready, 1);
        check("bus_req_ready", bus_if.bus_req, 0);
        check_line("line_ready", base, s);
        bus_if.mem_r = 1'b0;
        tick();
        check("mem_ready_one_cycle", bus_if.mem_ready, 0);
        check("bus_req_idle", bus_if.bus_req, 0);
    endtask

    initial begin
        int rdy0;
        int err0;

        rst              = 1'b1;
        bus_if.mem_r     = 1'b0;
        bus_if.miss_addr = '0;
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_err   = 1'b0;
        bus_if.bus_rdata = '0;
        salt             = '0;
        repeat (2) tick();

        // Reset state.
        check("rst_mem_ready", bus_if.mem_ready, 0);
        check("rst_fill_err", bus_if.fill_err, 0);
        check("rst_bus_req", bus_if.bus_req, 0);
        check("rst_bus_addr", bus_if.bus_addr, 32'h0);
        check("rst_line_w0", bus_if.line_data[31:0], 32'h0);
        check("rst_line_w7", bus_if.line_data[255:224], 32'h0);
        rst = 1'b0;
        tick();

        // Critical word first at 0x1008, ack every cycle: ready at T+9.
        full_fill(32'h0000_1008, 0, 32'h5A00_0000);
        check("word2_first_rdata", bus_if.line_data[95:64], 32'h5A00_1008);

        // Stray ack while idle is ignored.
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h1234_5678;
        tick();
        bus_if.bus_ack   = 1'b0;
        check("idle_ack_bus_req", bus_if.bus_req, 0);
        check("idle_ack_ready", bus_if.mem_ready, 0);
        check_line("idle_ack_line", 32'h0000_1000, 32'h5A00_0000);

        // Start at last word of line, two wait cycles per beat.
        full_fill(32'h0000_101C, 2, 32'h3C00_0000);

        // Bus error on beat 4.
        rdy0             = ready_seen;
        err0             = err_seen;
        salt             = 32'h7100_0000;
        bus_if.mem_r     = 1'b1;
        bus_if.miss_addr = 32'h0000_2040;
        tick();
        for (int k = 0; k < 4; k++) do_beat(32'h0000_2040 + 32'(4*k), 0, 1'b0);
        do_beat(32'h0000_2050, 0, 1'b1);
        check("err_fill_err", bus_if.fill_err, 1);
        check("err_bus_req", bus_if.bus_req, 0);
        check("err_mem_ready", bus_if.mem_ready, 0);
        bus_if.mem_r = 1'b0;
        tick();
        check("err_pulse_end", bus_if.fill_err, 0);
        check("err_pulse_count", 32'(err_seen - err0), 32'd1);
        check("err_no_ready", 32'(ready_seen - rdy0), 32'd0);
        check_line("err_line_kept", 32'h0000_1000, 32'h3C00_0000);

        // Next fill after an error succeeds.
        full_fill(32'h0000_2040, 0, 32'h7200_0000);

        // Abort: mem_r dropped during beat 3, ack arrives on third cycle.
        rdy0             = ready_seen;
        err0             = err_seen;
        salt             = 32'h0E00_0000;
        bus_if.mem_r     = 1'b1;
        bus_if.miss_addr = 32'h0000_3010;
        tick();
        do_beat(32'h0000_3010, 0, 1'b0);
        do_beat(32'h0000_3014, 0, 1'b0);
        do_beat(32'h0000_3018, 0, 1'b0);
        bus_if.mem_r = 1'b0;
        check("abort_addr_c1", bus_if.bus_addr, 32'h0000_301C);
        tick();
        check("abort_bus_req_c2", bus_if.bus_req, 1);
        check("abort_addr_c2", bus_if.bus_addr, 32'h0000_301C);
        tick();
        check("abort_bus_req_c3", bus_if.bus_req, 1);
        check("abort_addr_c3", bus_if.bus_addr, 32'h0000_301C);
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'hBAD0_BAD0;
        tick();
        bus_if.bus_ack   = 1'b0;
        check("abort_bus_req_done", bus_if.bus_req, 0);
        check("abort_mem_ready", bus_if.mem_ready, 0);
        check("abort_fill_err", bus_if.fill_err, 0);
        tick();
        check("abort_no_ready", 32'(ready_seen - rdy0), 32'd0);
        check("abort_no_err", 32'(err_seen - err0), 32'd0);
        check_line("abort_line_kept", 32'h0000_2040, 32'h7200_0000);

        // Reset during beat 5, then a clean fill from beat 0.
        salt             = 32'h4400_0000;
        bus_if.mem_r     = 1'b1;
        bus_if.miss_addr = 32'h0000_4000;
        tick();
        for (int k = 0; k < 5; k++) do_beat(32'h0000_4000 + 32'(4*k), 0, 1'b0);
        check("rst_mid_addr", bus_if.bus_addr, 32'h0000_4014);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_bus_req", bus_if.bus_req, 0);
        check("rstmid_bus_addr", bus_if.bus_addr, 32'h0);
        check("rstmid_mem_ready", bus_if.mem_ready, 0);
        check("rstmid_fill_err", bus_if.fill_err, 0);
        check("rstmid_line_w0", bus_if.line_data[31:0], 32'h0);
        check("rstmid_line_w7", bus_if.line_data[255:224], 32'h0);
        full_fill(32'h0000_4004, 0, 32'h5500_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
